// File: rtl/jk_driver_pkg.sv
// Shared types and constants for the JK flip-flop excitation driver.
package jk_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    localparam logic MODE_EXPLICIT = 1'b0;
    localparam logic MODE_MINIMAL  = 1'b1;

    localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/jk_driver_excite.sv
// Combinational excitation lookup: requested next q plus current q -> (j, k).
module jk_excite
    import jk_driver_pkg::*;
(
    input  logic tgt,
    input  logic qm,
    input  logic mode,
    output logic j,
    output logic k
);

    always_comb begin
        j = tgt;
        k = ~tgt;
        // Minimal style: hold when already there, toggle otherwise.
        if (mode == MODE_MINIMAL) begin
            j = tgt ^ qm;
            k = tgt ^ qm;
        end
    end

endmodule

// File: rtl/jk_driver.sv
// Queues requested flip-flop states, drives j/k for one cycle each and
// verifies the flip-flop's q afterwards, counting mismatches.
module jk_driver
    import jk_driver_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tgt_valid,
    input  logic                 tgt_bit,
    output logic                 tgt_ready,
    input  logic                 mode,
    input  logic                 q_fb,
    output logic                 j,
    output logic                 k,
    output logic                 busy,
    output logic                 mismatch,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = DEPTH[AW:0];

    logic          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    state_t        state;
    logic          exp_bit;
    logic          qm;
    logic          push;
    logic          pop;
    logic          head;
    logic          qm_eff;
    logic          ex_j;
    logic          ex_k;

    assign tgt_ready = (count != FULL);
    assign push      = tgt_valid && tgt_ready;
    assign pop       = (state != ST_DRIVE) && (count != '0);
    assign head      = mem[rd_ptr];
    assign busy      = (count != '0) || (state != ST_IDLE);

    // A pop straight out of CHECK must see the q that qm is about to load.
    assign qm_eff = (state == ST_CHECK) ? q_fb : qm;

    jk_excite u_excite (
        .tgt  (head),
        .qm   (qm_eff),
        .mode (mode),
        .j    (ex_j),
        .k    (ex_k)
    );

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tgt_bit;
        end
        if (pop) begin
            exp_bit <= head;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            state    <= ST_IDLE;
            j        <= 1'b0;
            k        <= 1'b0;
            qm       <= 1'b0;
            mismatch <= 1'b0;
            err_cnt  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count    <= count + (AW+1)'(push) - (AW+1)'(pop);
            j        <= 1'b0;
            k        <= 1'b0;
            mismatch <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        j     <= ex_j;
                        k     <= ex_k;
                        state <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    state <= ST_CHECK;
                end
                ST_CHECK: begin
                    qm <= q_fb;
                    if (q_fb != exp_bit) begin
                        mismatch <= 1'b1;
                        if (err_cnt != '1) begin
                            err_cnt <= err_cnt + 1'b1;
                        end
                    end
                    if (pop) begin
                        j     <= ex_j;
                        k     <= ex_k;
                        state <= ST_DRIVE;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_driver.sv
// Bench for jk_driver: behavioural JK flip-flop on j/k/q_fb, queue-based
// transaction model, directed scenarios followed by randomized traffic.
module tb_jk_driver;
    import jk_driver_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       tgt_valid;
    logic       tgt_bit;
    logic       tgt_ready;
    logic       mode;
    logic       q_fb;
    logic       j;
    logic       k;
    logic       busy;
    logic       mismatch;
    logic [7:0] err_cnt;

    logic ffq;
    logic stuck;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) ffq <= 1'b0;
        else begin
            case ({j, k})
                2'b01:   ffq <= 1'b0;
                2'b10:   ffq <= 1'b1;
                2'b11:   ffq <= ~ffq;
                default: ffq <= ffq;
            endcase
        end
    end

    assign q_fb = stuck ? 1'b0 : ffq;

    jk_driver #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .tgt_valid (tgt_valid),
        .tgt_bit   (tgt_bit),
        .tgt_ready (tgt_ready),
        .mode      (mode),
        .q_fb      (q_fb),
        .j         (j),
        .k         (k),
        .busy      (busy),
        .mismatch  (mismatch),
        .err_cnt   (err_cnt)
    );

    // Transaction model: pending targets, one target in its drive cycle,
    // one in its check cycle, and the flip-flop's q as seen on q_fb.
    bit fq[$];
    bit mq;
    bit drv, chk;
    bit dj, dk, dt, ct;
    bit mis;
    int err;
    int n_cmp = 0;
    int n_bad = 0;
    int pulses = 0;
    bit saw_full = 0;

    function automatic bit jk_next(bit q, bit jj, bit kk);
        return (jj & ~q) | (~kk & q);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic step(input bit v, input bit b, input bit m, input bit r);
        bit was_drv;
        bit acc;
        tgt_valid = v;
        tgt_bit   = b;
        mode      = m;
        rst       = r;
        if (r) begin
            fq.delete();
            drv = 0; chk = 0; mq = 0; err = 0; mis = 0;
        end else begin
            was_drv = drv;
            acc = v && (fq.size() < DEPTH);
            mis = 0;
            if (chk) begin
                if (mq != ct) begin
                    mis = 1;
                    if (err < 255) err++;
                end
                chk = 0;
            end
            if (drv) begin
                mq  = stuck ? 1'b0 : jk_next(mq, dj, dk);
                chk = 1;
                ct  = dt;
                drv = 0;
            end
            if (!was_drv && fq.size() > 0) begin
                dt = fq.pop_front();
                if (m == MODE_EXPLICIT) {dj, dk} = dt ? 2'b10 : 2'b01;
                else                    {dj, dk} = (dt != mq) ? 2'b11 : 2'b00;
                drv = 1;
            end
            if (acc) fq.push_back(b);
        end
        @(posedge clk);
        @(negedge clk);
        check("j", j, drv ? dj : 1'b0);
        check("k", k, drv ? dk : 1'b0);
        check("mismatch", mismatch, mis);
        check("err_cnt", err_cnt, err);
        check("tgt_ready", tgt_ready, fq.size() < DEPTH);
        check("busy", busy, (fq.size() > 0) || drv || chk);
        if (chk && !stuck) check("q_fb", q_fb, ct);
        if (mismatch === 1'b1) pulses++;
        if (tgt_ready === 1'b0) saw_full = 1;
    endtask

    // Offer a sequence of targets, holding each until the model accepts it.
    task automatic push_seq(input bit bits[$], input bit m);
        int idx = 0;
        int guard = 0;
        while (idx < bits.size() && guard < 2000) begin
            bit will;
            will = fq.size() < DEPTH;
            step(1, bits[idx], m, 0);
            if (will) idx++;
            guard++;
        end
        check("push_seq_done", idx, bits.size());
    endtask

    task automatic idle(input int n, input bit m);
        for (int i = 0; i < n; i++) step(0, 0, m, 0);
    endtask

    initial begin
        bit seq[$];
        int guard;
        tgt_valid = 0; tgt_bit = 0; mode = 0; rst = 1; stuck = 0;

        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("reset_err", err_cnt, 0);

        // Explicit set/reset: 1,0,1
        seq = '{1, 0, 1};
        push_seq(seq, MODE_EXPLICIT);
        idle(8, MODE_EXPLICIT);
        check("explicit_final_q", q_fb, 1);

        // Minimal hold/toggle from q=0: 1,1,0,0
        step(0, 0, 0, 1);
        seq = '{1, 1, 0, 0};
        push_seq(seq, MODE_MINIMAL);
        idle(10, MODE_MINIMAL);
        check("minimal_final_q", q_fb, 0);
        check("minimal_err", err_cnt, 0);

        // Back-to-back burst long enough to fill the FIFO
        step(0, 0, 0, 1);
        saw_full = 0;
        seq = '{1, 0, 0, 1, 1, 0, 1};
        push_seq(seq, MODE_EXPLICIT);
        check("burst_full_seen", saw_full, 1);
        idle(20, MODE_EXPLICIT);
        check("burst_drained", busy, 0);

        // q_fb stuck at 0, 300 targets of 1
        step(0, 0, 0, 1);
        stuck = 1;
        pulses = 0;
        seq.delete();
        for (int i = 0; i < 300; i++) seq.push_back(1'b1);
        push_seq(seq, MODE_EXPLICIT);
        idle(10, MODE_EXPLICIT);
        check("stuck_pulses", pulses, 300);
        check("stuck_err_sat", err_cnt, 255);
        stuck = 0;
        step(0, 0, 0, 1);

        // Reset while driving with three targets queued
        guard = 0;
        while (!(drv && fq.size() == 3) && guard < 40) begin
            step(1, 1, MODE_EXPLICIT, 0);
            guard++;
        end
        check("rst_setup_reached", drv && fq.size() == 3, 1);
        step(1, 1, MODE_EXPLICIT, 1);
        check("rst_j", j, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", tgt_ready, 1);
        step(0, 0, 0, 0);
        check("rst_no_pulse", mismatch, 0);

        // Randomized traffic with occasional mode changes and resets
        begin
            bit m = 0;
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 15) == 0) m = ~m;
                step($urandom_range(0, 9) < 6, 1'($urandom), m,
                     $urandom_range(0, 63) == 0);
            end
            idle(20, m);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
